// File: rtl/conv_pkg.sv
// Shared encodings and constants for the streaming 3x3 convolver.
package conv_pkg;

  // Kernel select values, sampled on the start cycle.
  localparam logic [1:0] MODE_GAUSS = 2'b00;
  localparam logic [1:0] MODE_LAP   = 2'b01;
  localparam logic [1:0] MODE_PASS  = 2'b10;

  // Frame sequencer states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  // Gaussian 1-2-1 kernel: corners weight 1, edges 2 (<<1), centre 4 (<<2).
  // The weights sum to 16, so the normalising shift is 4.
  localparam int GAUSS_LOG_EDGE   = 1;
  localparam int GAUSS_LOG_CENTRE = 2;
  localparam int GAUSS_SHIFT      = 4;

  // Laplacian centre weight 8 as a shift.
  localparam int LAP_LOG_CENTRE = 3;

  // Guard bits on top of PW for the signed accumulator.
  localparam int ACC_GUARD = 5;

endpackage

// File: rtl/conv_line_buffer.sv
// Two-row line buffer indexed by column: holds the pixel one row back and
// two rows back at every column. Reads are combinational at the current
// column; a write pushes the new pixel in and ages the old one by a row.
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int PW    = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] addr_i,
  input  logic [PW-1:0] din_i,
  output logic [PW-1:0] row1_o,
  output logic [PW-1:0] row2_o
);

  logic [PW-1:0] row1_mem [DEPTH];
  logic [PW-1:0] row2_mem [DEPTH];

  // Shift the column's history down one row on every accepted pixel.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      row1_mem[addr_i] <= din_i;
      row2_mem[addr_i] <= row1_mem[addr_i];
    end
  end

  assign row1_o = row1_mem[addr_i];
  assign row2_o = row2_mem[addr_i];

endmodule

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolver: raster-order pixels in, interior filtered pixels
// out with their centre coordinates, two clock edges after the pixel that
// completes each window.
module conv3x3_stream
  import conv_pkg::*;
#(
  parameter int IMG_W = 512,
  parameter int IMG_H = 512,
  parameter int PW    = 16,
  parameter int XW    = $clog2(IMG_W),
  parameter int YW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    cfg_mode,
  input  logic          in_valid,
  input  logic [PW-1:0] in_pix,
  output logic          out_valid,
  output logic [PW-1:0] out_pix,
  output logic [XW-1:0] out_x,
  output logic [YW-1:0] out_y,
  output logic          busy,
  output logic          frame_done
);

  localparam int ACC_W = PW + ACC_GUARD;
  localparam logic [XW-1:0] COL_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(IMG_H - 1);
  localparam logic signed [ACC_W-1:0] PIX_MAX =
    $signed({{ACC_GUARD{1'b0}}, {PW{1'b1}}});

  // Zero-extend an unsigned pixel into the signed accumulator domain.
  function automatic logic signed [ACC_W-1:0] ext(input logic [PW-1:0] p);
    return $signed({{ACC_GUARD{1'b0}}, p});
  endfunction

  // Gaussian normalisation: arithmetic shift, truncating toward -inf.
  function automatic logic [PW-1:0] trunc_gauss(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> GAUSS_SHIFT;
    return s[PW-1:0];
  endfunction

  // Clamp a signed sum into the unsigned pixel range.
  function automatic logic [PW-1:0] sat_pix(input logic signed [ACC_W-1:0] a);
    if (a[ACC_W-1])   return '0;
    if (a > PIX_MAX)  return '1;
    return a[PW-1:0];
  endfunction

  // Final per-mode conversion of the accumulator to a pixel.
  function automatic logic [PW-1:0] finish_pix(input logic signed [ACC_W-1:0] a,
                                               input logic [1:0] m);
    case (m)
      MODE_GAUSS: return trunc_gauss(a);
      MODE_LAP:   return sat_pix(a);
      MODE_PASS:  return a[PW-1:0];
      default:    return a[PW-1:0];
    endcase
  endfunction

  state_t        state_q;
  logic [XW-1:0] col_q;
  logic [YW-1:0] row_q;
  logic [1:0]    mode_q;
  logic          drain_q;
  logic          busy_q;
  logic          frame_done_q;

  logic [2:0][2:0][PW-1:0] win_q;
  logic          vld_p0;
  logic [XW-1:0] x_p0;
  logic [YW-1:0] y_p0;

  logic                    vld_p1;
  logic signed [ACC_W-1:0] acc_p1;
  logic [1:0]              mode_p1;
  logic [XW-1:0]           x_p1;
  logic [YW-1:0]           y_p1;

  logic          out_valid_q;
  logic [PW-1:0] out_pix_q;
  logic [XW-1:0] out_x_q;
  logic [YW-1:0] out_y_q;

  logic          accept;
  logic [PW-1:0] lb_row1;
  logic [PW-1:0] lb_row2;

  logic signed [ACC_W-1:0] sum_edge;
  logic signed [ACC_W-1:0] sum_corner;
  logic signed [ACC_W-1:0] acc_d;

  assign accept = (state_q == S_RUN) && in_valid;

  conv_line_buffer #(
    .DEPTH (IMG_W),
    .PW    (PW),
    .AW    (XW)
  ) u_lbuf (
    .clk     (clk),
    .wr_en_i (accept),
    .addr_i  (col_q),
    .din_i   (in_pix),
    .row1_o  (lb_row1),
    .row2_o  (lb_row2)
  );

  // Frame sequencer: latch mode, walk the raster, drain, pulse frame_done.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      mode_q       <= MODE_GAUSS;
      drain_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // A start coinciding with frame_done is dropped.
          if (start && !frame_done_q) begin
            state_q <= S_RUN;
            mode_q  <= cfg_mode;
            col_q   <= '0;
            row_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_RUN: begin
          if (in_valid) begin
            if (col_q == COL_LAST) begin
              col_q <= '0;
              if (row_q == ROW_LAST) begin
                row_q   <= '0;
                drain_q <= 1'b0;
                state_q <= S_DRAIN;
              end else begin
                row_q <= row_q + 1'b1;
              end
            end else begin
              col_q <= col_q + 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (drain_q) begin
            drain_q      <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b1;
            state_q      <= S_IDLE;
          end else begin
            drain_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---- stage p0: window shift on each accepted pixel ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_q  <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vld_p0 <= accept && (col_q >= XW'(2)) && (row_q >= YW'(2));
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= lb_row2;
        win_q[1][2] <= lb_row1;
        win_q[2][2] <= in_pix;
      end
    end
  end

  // Centre coordinate of the window just completed.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_p0 <= col_q - 1'b1;
      y_p0 <= row_q - 1'b1;
    end
  end

  // Kernel sums over the current window.
  always_comb begin
    sum_edge   = ext(win_q[0][1]) + ext(win_q[1][0]) + ext(win_q[1][2]) + ext(win_q[2][1]);
    sum_corner = ext(win_q[0][0]) + ext(win_q[0][2]) + ext(win_q[2][0]) + ext(win_q[2][2]);
    case (mode_q)
      MODE_GAUSS: acc_d = sum_corner + (sum_edge <<< GAUSS_LOG_EDGE)
                          + (ext(win_q[1][1]) <<< GAUSS_LOG_CENTRE);
      MODE_LAP:   acc_d = (ext(win_q[1][1]) <<< LAP_LOG_CENTRE) - (sum_edge + sum_corner);
      default:    acc_d = ext(win_q[1][1]);
    endcase
  end

  // ---- stage p1: registered accumulator ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= vld_p0;
  end

  // Accumulator and tags advance every cycle; validity is carried by vld_p1.
  always_ff @(posedge clk) begin
    acc_p1  <= acc_d;
    mode_p1 <= mode_q;
    x_p1    <= x_p0;
    y_p1    <= y_p0;
  end

  // ---- stage p2: rounding/saturation into the output registers ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_pix_q   <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else begin
      out_valid_q <= vld_p1;
      if (vld_p1) begin
        out_pix_q <= finish_pix(acc_p1, mode_p1);
        out_x_q   <= x_p1;
        out_y_q   <= y_p1;
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pix    = out_pix_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule
